// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer with byte-strobed word memory, wait states, protected region and error responses
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int STRB_WIDTH  = DATA_WIDTH / 8,
  parameter int MEM_DEPTH   = 32,
  parameter int WAIT_CYCLES = 2,
  parameter int PROT_BASE   = 'h40
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PSELx,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_WIDTH-1:0] PSTRB,
  input  logic [2:0]            PPROT,
  input  logic                  PWAKEUP,
  input  logic                  delay_by_slave_module,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam int MIW = $clog2(MEM_DEPTH);
  localparam int CW  = $clog2(WAIT_CYCLES + 1);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [MIW-1:0] idx_q, r_idx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic [CW-1:0] cnt;
  logic wr_q, err_q, setup, err_in, load, respond, done, commit, dec, r_wr, r_err;
  logic unused_ok;
  assign unused_ok = ^{PWAKEUP, PPROT[2:1]};
  assign setup = PSELx & ~PENABLE;
  assign err_in = (32'(PADDR >> LSB) >= 32'(MEM_DEPTH)) | (PADDR[LSB-1:0] != '0) |
                  (~PWRITE & (PSTRB != '0)) |
                  (PWRITE & (PADDR >= ADDR_WIDTH'(PROT_BASE)) & ~PPROT[0]);
  // zero-wait responses are driven at the setup edge, so they use the live bus
  assign r_wr  = state == IDLE ? PWRITE : wr_q;
  assign r_err = state == IDLE ? err_in : err_q;
  assign r_idx = state == IDLE ? PADDR[LSB +: MIW] : idx_q;
  always_ff @(posedge PCLK)
    state <= PRESET ? IDLE : state_n;
  always_comb begin
    state_n = state;
    load    = 1'b0;
    respond = 1'b0;
    done    = 1'b0;
    commit  = 1'b0;
    dec     = 1'b0;
    if (state == IDLE) begin
      load    = setup;
      respond = setup & ~delay_by_slave_module;
      state_n = setup ? ACCESS : IDLE;
    end else if (!PSELx) begin
      done    = 1'b1;
      state_n = IDLE;
    end else if (PREADY) begin
      done    = 1'b1;
      commit  = wr_q & ~err_q;
      state_n = IDLE;
    end else if (PENABLE) begin
      respond = cnt == CW'(1);
      dec     = cnt != CW'(1);
    end
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      cnt     <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (load) begin
        idx_q   <= PADDR[LSB +: MIW];
        wr_q    <= PWRITE;
        wdata_q <= PWDATA;
        strb_q  <= PSTRB;
        err_q   <= err_in;
        cnt     <= delay_by_slave_module ? CW'(WAIT_CYCLES) : '0;
      end
      if (dec) cnt <= cnt - CW'(1);
      if (respond) begin
        PREADY  <= 1'b1;
        PSLVERR <= r_err;
        if (!r_wr) PRDATA <= r_err ? '0 : mem[r_idx];
      end
      if (done) begin
        PREADY  <= 1'b0;
        PSLVERR <= 1'b0;
      end
      if (commit)
        for (int i = 0; i < STRB_WIDTH; i++)
          if (strb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: table-driven APB transfers with a response scoreboard plus abort/reset sequences
module tb_apb_slave_mem;
  logic        PCLK = 1'b0;
  logic        PRESET, PSELx, PENABLE, PWRITE, PWAKEUP, delay_by_slave_module;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR;
  logic [31:0] PRDATA;
  int pass_cnt = 0, total_cnt = 0;

  apb_slave_mem dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PWAKEUP(PWAKEUP),
    .delay_by_slave_module(delay_by_slave_module),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic        dly;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] waits;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic xfer(input vec_t v);
    exp_t e;
    int w;
    e.rd = ~v.wr;
    e.err = v.err;
    e.rdata = v.rdata;
    e.waits = v.dly ? 32'd2 : 32'd0;
    sbq.push_back(e);
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = v.addr; PWRITE = v.wr; PWDATA = v.data;
    PSTRB = v.strb; PPROT = v.prot; delay_by_slave_module = v.dly;
    @(negedge PCLK);
    PENABLE = 1'b1;
    w = 0;
    while (!PREADY && w < 20) begin
      w++;
      @(negedge PCLK);
    end
    e = sbq.pop_front();
    chk("pready", {31'd0, PREADY}, 32'd1);
    chk("waits", w, e.waits);
    chk("pslverr", {31'd0, PSLVERR}, {31'd0, e.err});
    if (e.rd) chk("prdata", PRDATA, e.rdata);
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0;
    chk("pready_drop", {31'd0, PREADY}, 32'd0);
    chk("pslverr_drop", {31'd0, PSLVERR}, 32'd0);
  endtask

  function automatic vec_t rd(input logic [7:0] a, input logic [3:0] s, input logic d,
                              input logic e, input logic [31:0] x);
    return '{wr: 1'b0, addr: a, data: 32'h0, strb: s, prot: 3'b000, dly: d, err: e, rdata: x};
  endfunction

  function automatic vec_t wr(input logic [7:0] a, input logic [31:0] x, input logic [3:0] s,
                              input logic [2:0] p, input logic d, input logic e);
    return '{wr: 1'b1, addr: a, data: x, strb: s, prot: p, dly: d, err: e, rdata: 32'h0};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = rd(8'h04, 4'h0, 1'b0, 1'b0, 32'h0);
    vecs[1]  = wr(8'h08, 32'h12345678, 4'b1111, 3'b000, 1'b0, 1'b0);
    vecs[2]  = wr(8'h08, 32'hAABBCCDD, 4'b0101, 3'b000, 1'b0, 1'b0);
    vecs[3]  = rd(8'h08, 4'h0, 1'b0, 1'b0, 32'h12BB56DD);
    vecs[4]  = rd(8'h08, 4'h0, 1'b1, 1'b0, 32'h12BB56DD);
    vecs[5]  = rd(8'h80, 4'h0, 1'b0, 1'b1, 32'h0);
    vecs[6]  = wr(8'h05, 32'hFFFFFFFF, 4'b1111, 3'b001, 1'b0, 1'b1);
    vecs[7]  = rd(8'h04, 4'h0, 1'b0, 1'b0, 32'h0);
    vecs[8]  = wr(8'h40, 32'hDEADBEEF, 4'b1111, 3'b000, 1'b0, 1'b1);
    vecs[9]  = rd(8'h40, 4'h0, 1'b0, 1'b0, 32'h0);
    vecs[10] = wr(8'h40, 32'hDEADBEEF, 4'b1111, 3'b001, 1'b0, 1'b0);
    vecs[11] = rd(8'h40, 4'h0, 1'b0, 1'b0, 32'hDEADBEEF);
    vecs[12] = rd(8'h08, 4'b0001, 1'b0, 1'b1, 32'h0);
    vecs[13] = wr(8'h7C, 32'h1234A5A5, 4'b0011, 3'b001, 1'b1, 1'b0);
    vecs[14] = rd(8'h7C, 4'h0, 1'b1, 1'b0, 32'h0000A5A5);
    vecs[15] = rd(8'h40, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF);

    PRESET = 1'b1; PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWAKEUP = 1'b0;
    delay_by_slave_module = 1'b0; PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
    repeat (2) @(negedge PCLK);
    chk("rst_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_prdata", PRDATA, 32'd0);
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);

    for (int i = 0; i < 16; i++) xfer(vecs[i]);

    // access phase without a preceding setup is ignored
    PSELx = 1'b1; PENABLE = 1'b1; PADDR = 8'h08; PWRITE = 1'b0; PSTRB = '0;
    delay_by_slave_module = 1'b0;
    repeat (2) begin
      @(negedge PCLK);
      chk("no_setup_pready", {31'd0, PREADY}, 32'd0);
    end
    PSELx = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);

    // master abort mid-wait on a write to 0x10
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = 8'h10; PWRITE = 1'b1; PWDATA = 32'h55AA55AA;
    PSTRB = 4'b1111; PPROT = 3'b001; delay_by_slave_module = 1'b1;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSELx = 1'b0; PENABLE = 1'b0;
    repeat (3) begin
      @(negedge PCLK);
      chk("abort_pready", {31'd0, PREADY}, 32'd0);
    end
    xfer(rd(8'h10, 4'h0, 1'b0, 1'b0, 32'h0));
    xfer(rd(8'h08, 4'h0, 1'b0, 1'b0, 32'h12BB56DD));

    // reset during a wait-state write to 0x0C
    PSELx = 1'b1; PENABLE = 1'b0; PADDR = 8'h0C; PWRITE = 1'b1; PWDATA = 32'hCAFEF00D;
    PSTRB = 4'b1111; PPROT = 3'b001; delay_by_slave_module = 1'b1;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    chk("midrst_pready", {31'd0, PREADY}, 32'd0);
    chk("midrst_prdata", PRDATA, 32'd0);
    PRESET = 1'b0; PSELx = 1'b0; PENABLE = 1'b0;
    repeat (2) begin
      @(negedge PCLK);
      chk("postrst_pready", {31'd0, PREADY}, 32'd0);
    end
    xfer(rd(8'h0C, 4'h0, 1'b0, 1'b0, 32'h0));
    xfer(rd(8'h08, 4'h0, 1'b1, 1'b0, 32'h0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
